vga_frame_signature: RTL

//  Synthesisable monitor for the VGA output stream (hs, vs, r, g, b).
//  - Measures line length and frame height.
//  - Computes a CRC-16 signature over every pixel clock of each frame.
//  - Reports one result per frame, so gameplay regressions are checked by

---
 rtl/vga_frame_signature.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vga_frame_signature.sv
// VGA stream monitor: measures line length and frame height, and builds a CRC-16
// signature over every pixel clock of each frame, reporting once per frame.
module vga_frame_signature #(
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned H_TOTAL  = 1344,
  parameter int unsigned V_TOTAL  = 806,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               hs,
  input  logic               vs,
  input  logic [COLOR_W-1:0] r,
  input  logic [COLOR_W-1:0] g,
  input  logic [COLOR_W-1:0] b,
  output logic [15:0]        sig,
  output logic               sig_valid,
  output logic [15:0]        frame_cnt,
  output logic               h_err,
  output logic               v_err
);

  localparam int unsigned PIX_W = 3 * COLOR_W;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_hs_q;
  logic        r_vs_q;
  logic [15:0] r_crc;
  logic [15:0] r_pix_cnt;
  logic [15:0] r_line_cnt;
  logic        r_h_bad;
  logic [15:0] r_sig;
  logic        r_sig_valid;
  logic [15:0] r_frame_cnt;
  logic        r_h_err;
  logic        r_v_err;

  logic             w_hs_lead;
  logic             w_vs_lead;
  logic             w_init;
  logic             w_start;
  logic             w_close;
  logic             w_run;
  logic [PIX_W-1:0] w_pix;
  logic [15:0]      w_crc_nxt;
  logic [15:0]      w_line_hs;
  logic             w_h_bad_hs;

  // CCITT CRC, MSB-first, one whole pixel per call
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [PIX_W-1:0] d);
    logic [15:0] v;
    v = c;
    for (int i = PIX_W - 1; i >= 0; i--) begin
      if (v[15] ^ d[i]) v = {v[14:0], 1'b0} ^ CRC_POLY;
      else              v = {v[14:0], 1'b0};
    end
    return v;
  endfunction

  assign w_hs_lead = (hs == SYNC_POL) && (r_hs_q != SYNC_POL);
  assign w_vs_lead = (vs == SYNC_POL) && (r_vs_q != SYNC_POL);
  assign w_pix     = {r, g, b};
  assign w_crc_nxt = crc_step(w_start ? CRC_INIT : r_crc, w_pix);

  // A coincident hs edge is folded into the ending frame before it closes
  assign w_line_hs  = (w_hs_lead && r_line_cnt != 16'hFFFF) ? r_line_cnt + 16'd1 : r_line_cnt;
  assign w_h_bad_hs = r_h_bad | (w_hs_lead && r_line_cnt != 16'd0 && r_pix_cnt != 16'(H_TOTAL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_q <= ~SYNC_POL;
      r_vs_q <= ~SYNC_POL;
    end else begin
      r_hs_q <= hs;
      r_vs_q <= vs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_nxt = SYNC;
      SYNC:    if (w_vs_lead) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
    if (!enable) w_state_nxt = IDLE;
  end

  always_comb begin
    w_init  = 1'b0;
    w_start = 1'b0;
    w_close = 1'b0;
    w_run   = 1'b0;
    case (r_state)
      IDLE: w_init = enable;
      SYNC: w_start = enable && w_vs_lead;
      RUN: begin
        w_run   = enable;
        w_start = enable && w_vs_lead;
        w_close = enable && w_vs_lead;
      end
      default: ;
    endcase
  end

  // Per-frame accumulation; the vs-edge pixel opens the new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc      <= CRC_INIT;
      r_pix_cnt  <= 16'd0;
      r_line_cnt <= 16'd0;
      r_h_bad    <= 1'b0;
    end else if (w_start) begin
      r_crc      <= w_crc_nxt;
      r_pix_cnt  <= 16'd1;
      r_line_cnt <= 16'd0;
      r_h_bad    <= 1'b0;
    end else if (w_init) begin
      r_crc      <= CRC_INIT;
      r_pix_cnt  <= 16'd1;
      r_line_cnt <= 16'd0;
      r_h_bad    <= 1'b0;
    end else if (w_run) begin
      r_crc      <= w_crc_nxt;
      r_line_cnt <= w_line_hs;
      r_h_bad    <= w_h_bad_hs;
      if (w_hs_lead)                   r_pix_cnt <= 16'd1;
      else if (r_pix_cnt != 16'hFFFF)  r_pix_cnt <= r_pix_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig       <= 16'd0;
      r_sig_valid <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_h_err     <= 1'b0;
      r_v_err     <= 1'b0;
    end else begin
      r_sig_valid <= w_close;
      if (w_close) begin
        r_sig       <= r_crc;
        r_h_err     <= w_h_bad_hs;
        r_v_err     <= (w_line_hs != 16'(V_TOTAL));
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign sig       = r_sig;
  assign sig_valid = r_sig_valid;
  assign frame_cnt = r_frame_cnt;
  assign h_err     = r_h_err;
  assign v_err     = r_v_err;

endmodule
